snake_game_ctrl: RTL and testbench

Game-state controller that owns the snake, food and game-over state consumed by the snake renderer. Advances the snake one cell every MOVE_DIV frame ticks and applies direction input with a no-reversal rule. Detects wall and self collision, grows the snake on food, and re-places food pseudo-randomly off the body. Sits between the button synchronisers and the renderer; its outputs connect directly to the renderer's snake_body_flat, snake_length, food_pos and game_over inputs.

---
 rtl/snake_pkg.sv | 21 ++
 rtl/snake_food_lfsr.sv | 19 +
 rtl/snake_game_ctrl.sv | 137 +++++++++++++
 tb/tb_snake_game_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared grid geometry, direction/state encodings, cell indexing and LFSR constants
// for the snake game controller.
package snake_pkg;
  localparam int GRID_W   = 100;
  localparam int GRID_H   = 75;
  localparam int MAX_LEN  = 64;
  localparam int POS_BITS = 13;
  localparam int XY_BITS  = 7;
  localparam int LEN_BITS = $clog2(MAX_LEN + 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_e;
  typedef enum logic [2:0] {IDLE, PLAY, STEP, FOOD, OVER} state_e;
  function automatic logic [POS_BITS-1:0] to_pos(input logic [XY_BITS-1:0] x, input logic [XY_BITS-1:0] y);
    return POS_BITS'(int'(y) * GRID_W + int'(x));
  endfunction
  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'd1);
  endfunction
endpackage

// File: rtl/snake_food_lfsr.sv
// snake_food_lfsr: free-running 16-bit LFSR offering a food cell candidate every cycle,
// flagged valid only when it lies inside the grid.
module snake_food_lfsr
  import snake_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  output logic [XY_BITS-1:0] cand_x,
  output logic [XY_BITS-1:0] cand_y,
  output logic               cand_ok
);
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) lfsr_q <= LFSR_SEED;
    else lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
  assign cand_x  = lfsr_q[6:0];
  assign cand_y  = lfsr_q[13:7];
  assign cand_ok = cand_x < XY_BITS'(GRID_W) && cand_y < XY_BITS'(GRID_H);
endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: snake movement, growth, collision and food placement feeding the renderer.
// Define WRAP_WALLS_EN to wrap the head at the grid edges instead of ending the game.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int MOVE_DIV  = 4,
  parameter int INIT_LEN  = 3,
  parameter int START_X   = 50,
  parameter int START_Y   = 37,
  parameter int FOOD_INIT = 1020
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        frame_tick,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_left,
  input  logic                        btn_right,
  input  logic                        btn_start,
  output logic [POS_BITS*MAX_LEN-1:0] snake_body_flat,
  output logic [LEN_BITS-1:0]         snake_length,
  output logic [POS_BITS-1:0]         food_pos,
  output logic                        game_over,
  output logic [7:0]                  score
);
  localparam int TB = MOVE_DIV > 1 ? $clog2(MOVE_DIV) : 1;
  state_e state_q;
  dir_e dir_q, req_q, btn_dir, ref_dir;
  logic [XY_BITS-1:0] hx_q, hy_q, nx, ny, cand_x, cand_y;
  logic [POS_BITS-1:0] seg_q [MAX_LEN];
  logic [POS_BITS-1:0] seg_d [MAX_LEN];
  logic [POS_BITS-1:0] food_q, head_d, cand_pos;
  logic [LEN_BITS-1:0] len_q, len_d, lim;
  logic [7:0] score_q;
  logic [TB-1:0] tick_q;
  logic over_q, pend_q, start_q, start_rise, trig, eat, self_hit, occupied, die, cand_ok;
  function automatic logic [POS_BITS-1:0] init_pos(input int i);
    return i < INIT_LEN ? to_pos(XY_BITS'(START_X - i), XY_BITS'(START_Y)) : '0;
  endfunction
  snake_food_lfsr u_lfsr (.clk(clk), .rstn(rstn), .cand_x(cand_x), .cand_y(cand_y), .cand_ok(cand_ok));
  always_comb begin
    start_rise = btn_start & ~start_q;
    trig = frame_tick && tick_q == TB'(MOVE_DIV - 1);
    btn_dir = btn_up ? UP : btn_down ? DOWN : btn_left ? LEFT : RIGHT;
    // a request made while stepping is judged against the direction being committed
    ref_dir = state_q == STEP ? req_q : dir_q;
    nx = req_q == LEFT  ? (hx_q == '0 ? XY_BITS'(GRID_W - 1) : hx_q - XY_BITS'(1)) :
         req_q == RIGHT ? (hx_q == XY_BITS'(GRID_W - 1) ? '0 : hx_q + XY_BITS'(1)) : hx_q;
    ny = req_q == UP    ? (hy_q == '0 ? XY_BITS'(GRID_H - 1) : hy_q - XY_BITS'(1)) :
         req_q == DOWN  ? (hy_q == XY_BITS'(GRID_H - 1) ? '0 : hy_q + XY_BITS'(1)) : hy_q;
    head_d = to_pos(nx, ny);
    eat = head_d == food_q;
    len_d = eat && len_q < LEN_BITS'(MAX_LEN) ? len_q + LEN_BITS'(1) : len_q;
    // the tail cell is vacated this step unless the snake grows
    lim = eat ? len_q : len_q - LEN_BITS'(1);
    cand_pos = to_pos(cand_x, cand_y);
    self_hit = 1'b0;
    occupied = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      self_hit |= head_d == seg_q[i] && LEN_BITS'(i) < lim;
      occupied |= cand_pos == seg_q[i] && LEN_BITS'(i) < len_q;
      seg_d[i] = LEN_BITS'(i) >= len_d ? '0 : i == 0 ? head_d : seg_q[i == 0 ? 0 : i - 1];
    end
`ifdef WRAP_WALLS_EN
    die = self_hit;
`else
    die = self_hit || (req_q == LEFT && hx_q == '0) || (req_q == RIGHT && hx_q == XY_BITS'(GRID_W - 1)) ||
          (req_q == UP && hy_q == '0) || (req_q == DOWN && hy_q == XY_BITS'(GRID_H - 1));
`endif
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      dir_q   <= RIGHT;
      req_q   <= RIGHT;
      hx_q    <= XY_BITS'(START_X);
      hy_q    <= XY_BITS'(START_Y);
      len_q   <= LEN_BITS'(INIT_LEN);
      food_q  <= POS_BITS'(FOOD_INIT);
      score_q <= '0;
      tick_q  <= '0;
      over_q  <= 1'b0;
      pend_q  <= 1'b0;
      start_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= init_pos(i);
    end else begin
      start_q <= btn_start;
      if (state_q != OVER && (btn_up | btn_down | btn_left | btn_right) && btn_dir != opposite(ref_dir)) req_q <= btn_dir;
      if (state_q inside {PLAY, STEP, FOOD} && frame_tick) tick_q <= trig ? '0 : tick_q + TB'(1);
      if (trig && state_q inside {STEP, FOOD}) pend_q <= 1'b1;
      case (state_q)
        IDLE: if (start_rise) state_q <= PLAY;
        PLAY: if (trig || pend_q) begin
          state_q <= STEP;
          pend_q  <= 1'b0;
        end
        STEP: if (die) begin
          state_q <= OVER;
          over_q  <= 1'b1;
        end else begin
          state_q <= eat ? FOOD : PLAY;
          hx_q    <= nx;
          hy_q    <= ny;
          dir_q   <= req_q;
          seg_q   <= seg_d;
          len_q   <= len_d;
          if (eat && score_q != 8'hFF) score_q <= score_q + 8'd1;
        end
        FOOD: if (cand_ok && !occupied) begin
          food_q  <= cand_pos;
          state_q <= PLAY;
        end
        default: if (start_rise) begin
          state_q <= PLAY;
          dir_q   <= RIGHT;
          req_q   <= RIGHT;
          hx_q    <= XY_BITS'(START_X);
          hy_q    <= XY_BITS'(START_Y);
          len_q   <= LEN_BITS'(INIT_LEN);
          food_q  <= POS_BITS'(FOOD_INIT);
          score_q <= '0;
          tick_q  <= '0;
          over_q  <= 1'b0;
          pend_q  <= 1'b0;
          for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= init_pos(i);
        end
      endcase
    end
  end
  for (genvar g = 0; g < MAX_LEN; g++) begin : g_body
    assign snake_body_flat[g*POS_BITS +: POS_BITS] = seg_q[g];
  end
  assign snake_length = len_q;
  assign food_pos     = food_q;
  assign game_over    = over_q;
  assign score        = score_q;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed checks of snake_game_ctrl movement, steering, walls, growth,
// food placement and reset; a second instance starts with food two cells ahead of the head.
module tb_snake_game_ctrl;
  import snake_pkg::*;
  logic clk = 0, rstn = 0, frame_tick = 0, btn_start = 0;
  logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
  logic [POS_BITS*MAX_LEN-1:0] body, body_f;
  logic [LEN_BITS-1:0] len, len_f;
  logic [POS_BITS-1:0] food, food_f;
  logic over, over_f;
  logic [7:0] score, score_f;
  int passed = 0, total = 0;
  typedef struct {
    logic [3:0] btn;
    int head;
    int seg1;
  } vec_t;
  vec_t vecs [8];
  always #5 clk = ~clk;
  snake_game_ctrl dut (
    .clk(clk), .rstn(rstn), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right), .btn_start(btn_start),
    .snake_body_flat(body), .snake_length(len), .food_pos(food), .game_over(over), .score(score)
  );
  snake_game_ctrl #(.FOOD_INIT(3752)) dut_f (
    .clk(clk), .rstn(rstn), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right), .btn_start(btn_start),
    .snake_body_flat(body_f), .snake_length(len_f), .food_pos(food_f), .game_over(over_f), .score(score_f)
  );
  function automatic int seg(input logic [POS_BITS*MAX_LEN-1:0] b, input int i);
    return int'(b[i*POS_BITS +: POS_BITS]);
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic tick();
    @(negedge clk); frame_tick = 1;
    @(negedge clk); frame_tick = 0;
    @(negedge clk);
    @(negedge clk);
  endtask
  task automatic step();
    repeat (4) tick();
  endtask
  task automatic press_start();
    @(negedge clk); btn_start = 1;
    @(negedge clk); btn_start = 0;
  endtask
  task automatic do_reset();
    @(negedge clk); rstn = 0;
    @(negedge clk); rstn = 1;
  endtask
  initial begin
    int found, clash;
    vecs[0] = '{4'b0000, 3751, 3750};
    vecs[1] = '{4'b0010, 3752, 3751};
    vecs[2] = '{4'b1000, 3652, 3752};
    vecs[3] = '{4'b0001, 3653, 3652};
    vecs[4] = '{4'b0100, 3753, 3653};
    vecs[5] = '{4'b0011, 3752, 3753};
    vecs[6] = '{4'b1001, 3652, 3752};
    vecs[7] = '{4'b0100, 3552, 3652};
    #12;
    chk("rst len", int'(len), 3);
    chk("rst seg0", seg(body, 0), 3750);
    chk("rst seg1", seg(body, 1), 3749);
    chk("rst seg2", seg(body, 2), 3748);
    chk("rst seg3", seg(body, 3), 0);
    chk("rst food", int'(food), 1020);
    chk("rst over", int'(over), 0);
    chk("rst score", int'(score), 0);
    @(negedge clk); rstn = 1;
    step();
    chk("idle no move", seg(body, 0), 3750);
    press_start();
    for (int v = 0; v < 8; v++) begin
      {btn_up, btn_down, btn_left, btn_right} = vecs[v].btn;
      step();
      {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
      chk($sformatf("vec%0d head", v), seg(body, 0), vecs[v].head);
      chk($sformatf("vec%0d seg1", v), seg(body, 1), vecs[v].seg1);
      chk($sformatf("vec%0d len", v), int'(len), 3);
    end
    do_reset();
    press_start();
    repeat (49) step();
    chk("head at x99", seg(body, 0), 3799);
    step();
`ifdef WRAP_WALLS_EN
    chk("wrap head", seg(body, 0), 3700);
    chk("wrap over", int'(over), 0);
    step();
    chk("wrap continue", seg(body, 0), 3701);
`else
    chk("wall over", int'(over), 1);
    chk("wall head", seg(body, 0), 3799);
    repeat (8) tick();
    chk("frozen over", int'(over), 1);
    chk("frozen head", seg(body, 0), 3799);
    chk("frozen seg2", seg(body, 2), 3797);
    press_start();
    @(negedge clk);
    chk("restart over", int'(over), 0);
    chk("restart head", seg(body, 0), 3750);
    chk("restart seg2", seg(body, 2), 3748);
    step();
    chk("restart step", seg(body, 0), 3751);
`endif
    do_reset();
    press_start();
    step();
    step();
    chk("eat len", int'(len_f), 4);
    chk("eat score", int'(score_f), 1);
    chk("eat seg0", seg(body_f, 0), 3752);
    chk("eat seg3", seg(body_f, 3), 3749);
    chk("no eat len", int'(len), 3);
    chk("no eat score", int'(score), 0);
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      if (food_f != 13'd3752) found = 1;
    end
    chk("food placed", found, 1);
    chk("food in grid", int'(food_f < 13'd7500), 1);
    clash = 0;
    for (int i = 0; i < 4; i++) if (seg(body_f, i) == int'(food_f)) clash++;
    chk("food off body", clash, 0);
    do_reset();
    press_start();
    step();
    repeat (3) tick();
    @(negedge clk); frame_tick = 1;
    @(negedge clk); frame_tick = 0;
    @(posedge clk);
    #1;
    chk("pre-rst grown", int'(len_f), 4);
    rstn = 0;
    #1;
    chk("async len", int'(len_f), 3);
    chk("async food", int'(food_f), 3752);
    chk("async score", int'(score_f), 0);
    chk("async seg0", seg(body_f, 0), 3750);
    chk("async seg3", seg(body_f, 3), 0);
    chk("async over", int'(over_f), 0);
    @(negedge clk); rstn = 1;
    press_start();
    step();
    chk("post-rst head", seg(body_f, 0), 3751);
    chk("post-rst len", int'(len_f), 3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
